// File: rtl/pe_conv_mac_ctrl_param.sv
// Convolution PE sequencer: walks G output-channel groups of K*K pixels and fires delayed per-group stage enables.
// Optional sticky busy-drop flag err_drop is built when PE_CTRL_BUSY_ERR_EN is defined.
module pe_conv_mac_ctrl_param #(
    parameter int pOUT_CHANNEL     = 64,
    parameter int pOUTPUT_PARALLEL = 16,
    parameter int pKERNEL_SIZE     = 3,
    parameter int pKERNEL_NUM      = 36,
    parameter int pBIAS_NUM        = 4,
    parameter int pBIAS_DLY        = 3,
    parameter int pADDER_DLY       = 4,
    parameter int pACT_DLY         = 4,
    parameter int pDEQUANT_DLY     = 5,
    parameter int pQUANT_DLY       = 8,
    parameter int pBUFFER_DLY      = 9,
    localparam int G     = pOUT_CHANNEL / pOUTPUT_PARALLEL,
    localparam int P     = pKERNEL_SIZE * pKERNEL_SIZE,
    localparam int PIX_W = (P > 1) ? $clog2(P) : 1,
    localparam int KA_W  = (pKERNEL_NUM > 1) ? $clog2(pKERNEL_NUM) : 1,
    localparam int BA_W  = (pBIAS_NUM > 1) ? $clog2(pBIAS_NUM) : 1,
    localparam int GI_W  = (G > 1) ? $clog2(G) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             buffer_valid,
    output logic [PIX_W-1:0] pixel,
    output logic [KA_W-1:0]  kernel_addr,
    output logic [BA_W-1:0]  bias_addr,
    output logic [GI_W-1:0]  buffer_idx,
    output logic             pe_ready,
    output logic             valid,
    output logic             pe_clr,
    output logic             datapath_buffer_en,
    output logic             bias_en,
    output logic             adder_en,
    output logic             act_en,
    output logic             dequant_en,
    output logic             quant_en,
    output logic             buffer_en,
    output logic             done
`ifdef PE_CTRL_BUSY_ERR_EN
    ,
    output logic             err_drop
`endif
);

    localparam int M1    = (pBIAS_DLY > pADDER_DLY) ? pBIAS_DLY : pADDER_DLY;
    localparam int M2    = (pACT_DLY > pDEQUANT_DLY) ? pACT_DLY : pDEQUANT_DLY;
    localparam int M3    = (pQUANT_DLY > pBUFFER_DLY) ? pQUANT_DLY : pBUFFER_DLY;
    localparam int M12   = (M1 > M2) ? M1 : M2;
    localparam int DEPTH = (M12 > M3) ? M12 : M3;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DRAIN} state_t;

    state_t           state_q, state_d;
    logic [PIX_W-1:0] pixel_q, pixel_d;
    logic [GI_W-1:0]  group_q, group_d;
    logic [KA_W-1:0]  kaddr_q, kaddr_d;
    logic [BA_W-1:0]  baddr_q, baddr_d;
    logic [GI_W-1:0]  bidx_q, bidx_d;
    logic [DEPTH-1:0] sr_q, sr_d;
    logic             done_q, done_d;
    logic             mac, last_pix, last_grp, launch;
`ifdef PE_CTRL_BUSY_ERR_EN
    logic             err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        pixel_d  = pixel_q;
        group_d  = group_q;
        kaddr_d  = kaddr_q;
        baddr_d  = baddr_q;
        bidx_d   = bidx_q;
        sr_d     = sr_q;
        done_d   = done_q;
        mac      = (state_q == S_MAC);
        last_pix = (pixel_q == PIX_W'(P - 1));
        last_grp = (group_q == GI_W'(G - 1));
        launch   = mac & last_pix;

        pe_ready           = (state_q == S_IDLE);
        valid              = buffer_valid & pe_ready & en;
        pe_clr             = en & mac & (pixel_q == '0);
        datapath_buffer_en = en & mac;
        bias_en            = en & sr_q[pBIAS_DLY-1];
        adder_en           = en & sr_q[pADDER_DLY-1];
        act_en             = en & sr_q[pACT_DLY-1];
        dequant_en         = en & sr_q[pDEQUANT_DLY-1];
        quant_en           = en & sr_q[pQUANT_DLY-1];
        buffer_en          = en & sr_q[pBUFFER_DLY-1];
        done               = en & done_q;

        if (en) begin
            // Tokens keep shifting in every state so late stages of the last group still fire.
            sr_d = (sr_q << 1) | DEPTH'(launch);
            unique case (state_q)
                S_IDLE: begin
                    if (buffer_valid) begin
                        state_d = S_MAC;
                        pixel_d = '0;
                        group_d = '0;
                        kaddr_d = '0;
                        baddr_d = '0;
                        bidx_d  = '0;
                    end
                end
                S_MAC: begin
                    kaddr_d = (kaddr_q == KA_W'(pKERNEL_NUM - 1)) ? '0 : kaddr_q + KA_W'(1);
                    if (last_pix) begin
                        pixel_d = '0;
                        baddr_d = (baddr_q == BA_W'(pBIAS_NUM - 1)) ? '0 : baddr_q + BA_W'(1);
                        if (last_grp) begin
                            group_d = '0;
                            state_d = S_DRAIN;
                        end else begin
                            group_d = group_q + GI_W'(1);
                        end
                    end else begin
                        pixel_d = pixel_q + PIX_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (done_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            // The G-th buffer write of a frame arms done for the following cycle.
            if (sr_q[pBUFFER_DLY-1]) begin
                bidx_d = (bidx_q == GI_W'(G - 1)) ? '0 : bidx_q + GI_W'(1);
                if (state_q == S_DRAIN && bidx_q == GI_W'(G - 1)) done_d = 1'b1;
            end
        end
    end

`ifdef PE_CTRL_BUSY_ERR_EN
    always_comb err_d = err_q | (buffer_valid & ~pe_ready & en);
    assign err_drop = err_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pixel_q <= '0;
            group_q <= '0;
            kaddr_q <= '0;
            baddr_q <= '0;
            bidx_q  <= '0;
            sr_q    <= '0;
            done_q  <= 1'b0;
`ifdef PE_CTRL_BUSY_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pixel_q <= pixel_d;
            group_q <= group_d;
            kaddr_q <= kaddr_d;
            baddr_q <= baddr_d;
            bidx_q  <= bidx_d;
            sr_q    <= sr_d;
            done_q  <= done_d;
`ifdef PE_CTRL_BUSY_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    assign pixel       = pixel_q;
    assign kernel_addr = kaddr_q;
    assign bias_addr   = baddr_q;
    assign buffer_idx  = bidx_q;

endmodule

// File: tb/tb_pe_conv_mac_ctrl_param.sv
// Bench for pe_conv_mac_ctrl_param: three parameterisations driven in lock-step against a progress-time reference model.
module tb_pe_conv_mac_ctrl_param;
    localparam int BIAS = 3, ADD = 4, ACT = 4, DEQ = 5, QNT = 8, BUF = 9, BN = 4;

    logic clk = 1'b0;
    logic rst = 1'b1, en = 1'b0, buffer_valid = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rdy_w, val_w, clr_w, dbe_w, bias_w, add_w, act_w, deq_w, qnt_w, buf_w, done_w, err_w;
    logic [3:0] pix0, pix2;
    logic [0:0] pix1, bi1;
    logic [5:0] k0, k1;
    logic [4:0] k2;
    logic [1:0] ba0, ba1, ba2, bi0, bi2;
    logic [25:0] obs [3];

    int checks = 0, errors = 0;
    int P_a[3]  = '{9, 1, 9};
    int G_a[3]  = '{4, 1, 4};
    int KN_a[3] = '{36, 36, 20};
    int  t_m[3];
    bit  act_m[3], known_m[3], err_m[3];

    pe_conv_mac_ctrl_param dut0 (
        .clk(clk), .rst(rst), .en(en), .buffer_valid(buffer_valid),
        .pixel(pix0), .kernel_addr(k0), .bias_addr(ba0), .buffer_idx(bi0),
        .pe_ready(rdy_w[0]), .valid(val_w[0]), .pe_clr(clr_w[0]), .datapath_buffer_en(dbe_w[0]),
        .bias_en(bias_w[0]), .adder_en(add_w[0]), .act_en(act_w[0]), .dequant_en(deq_w[0]),
        .quant_en(qnt_w[0]), .buffer_en(buf_w[0]), .done(done_w[0])
`ifdef PE_CTRL_BUSY_ERR_EN
        , .err_drop(err_w[0])
`endif
    );
    pe_conv_mac_ctrl_param #(.pKERNEL_SIZE(1), .pOUT_CHANNEL(16), .pOUTPUT_PARALLEL(16)) dut1 (
        .clk(clk), .rst(rst), .en(en), .buffer_valid(buffer_valid),
        .pixel(pix1), .kernel_addr(k1), .bias_addr(ba1), .buffer_idx(bi1),
        .pe_ready(rdy_w[1]), .valid(val_w[1]), .pe_clr(clr_w[1]), .datapath_buffer_en(dbe_w[1]),
        .bias_en(bias_w[1]), .adder_en(add_w[1]), .act_en(act_w[1]), .dequant_en(deq_w[1]),
        .quant_en(qnt_w[1]), .buffer_en(buf_w[1]), .done(done_w[1])
`ifdef PE_CTRL_BUSY_ERR_EN
        , .err_drop(err_w[1])
`endif
    );
    pe_conv_mac_ctrl_param #(.pKERNEL_NUM(20)) dut2 (
        .clk(clk), .rst(rst), .en(en), .buffer_valid(buffer_valid),
        .pixel(pix2), .kernel_addr(k2), .bias_addr(ba2), .buffer_idx(bi2),
        .pe_ready(rdy_w[2]), .valid(val_w[2]), .pe_clr(clr_w[2]), .datapath_buffer_en(dbe_w[2]),
        .bias_en(bias_w[2]), .adder_en(add_w[2]), .act_en(act_w[2]), .dequant_en(deq_w[2]),
        .quant_en(qnt_w[2]), .buffer_en(buf_w[2]), .done(done_w[2])
`ifdef PE_CTRL_BUSY_ERR_EN
        , .err_drop(err_w[2])
`endif
    );
`ifndef PE_CTRL_BUSY_ERR_EN
    assign err_w = '0;
`endif

    // Observation word: {err, buffer_idx, bias_addr, kernel_addr, pixel, 11 pulse/ready bits}.
    always_comb begin
        obs[0] = {err_w[0], bi0, ba0, k0, pix0, rdy_w[0], val_w[0], clr_w[0], dbe_w[0], bias_w[0],
                  add_w[0], act_w[0], deq_w[0], qnt_w[0], buf_w[0], done_w[0]};
        obs[1] = {err_w[1], 1'b0, bi1, ba1, k1, 3'b0, pix1, rdy_w[1], val_w[1], clr_w[1], dbe_w[1], bias_w[1],
                  add_w[1], act_w[1], deq_w[1], qnt_w[1], buf_w[1], done_w[1]};
        obs[2] = {err_w[2], bi2, ba2, 1'b0, k2, pix2, rdy_w[2], val_w[2], clr_w[2], dbe_w[2], bias_w[2],
                  add_w[2], act_w[2], deq_w[2], qnt_w[2], buf_w[2], done_w[2]};
    end

    // Reference: t counts enabled cycles since acceptance; group g ends at t=(g+1)*P.
    function automatic bit hit(int i, int t, int d);
        return (t - d >= P_a[i]) && ((t - d) % P_a[i] == 0) && ((t - d) / P_a[i] <= G_a[i]);
    endfunction

    function automatic void model_exp(input int i, input bit e, input bit bv,
                                      output logic [25:0] ev, output logic [25:0] mk);
        int  t = t_m[i], P = P_a[i], G = G_a[i];
        bit  a = act_m[i];
        bit  mac = a && t >= 1 && t <= G * P;
        bit  rdy = !a;
        bit  hb = a && hit(i, t, BUF);
        bit  idle_known = !a && known_m[i];
        int  px = mac ? (t - 1) % P : 0;
        int  ka = mac ? (t - 1) % KN_a[i] : 0;
        int  bb = mac ? ((t - 1) / P) % BN : 0;
        int  gi = hb ? (t - BUF) / P - 1 : 0;
        logic [10:0] pl;
        pl = {rdy, bv & rdy & e, e & mac & ((t - 1) % P == 0), e & mac,
              e & a & hit(i, t, BIAS), e & a & hit(i, t, ADD), e & a & hit(i, t, ACT),
              e & a & hit(i, t, DEQ), e & a & hit(i, t, QNT), e & hb,
              e & a & (t == G * P + BUF + 1)};
        ev = {err_m[i], 2'(gi), 2'(bb), 6'(ka), 4'(px), pl};
        mk = {1'b0, {2{hb | idle_known}}, {8{mac | idle_known}}, 4'hf, 11'h7ff};
`ifdef PE_CTRL_BUSY_ERR_EN
        mk[25] = 1'b1;
`endif
    endfunction

    function automatic void model_step(input int i, input bit e, input bit bv, input bit r);
        if (r) begin
            act_m[i] = 0; known_m[i] = 1; err_m[i] = 0; t_m[i] = 0;
            return;
        end
        if (bv && act_m[i] && e) err_m[i] = 1;
        if (e) begin
            if (act_m[i]) begin
                if (t_m[i] == G_a[i] * P_a[i] + BUF + 1) act_m[i] = 0;
                else t_m[i]++;
            end else if (bv) begin
                act_m[i] = 1; t_m[i] = 1; known_m[i] = 0;
            end
        end
    endfunction

    task automatic drive(input bit e, input bit bv, input bit r);
        @(posedge clk);
        #1;
        en = e; buffer_valid = bv; rst = r;
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [25:0] ev, mk;
        drive(1, 0, 1);
        for (int i = 0; i < 3; i++) model_step(i, 1, 0, 1);
        for (int c = 0; c < 5; c++) begin
            bit r = (c < 2);
            drive(1, 0, r);
            for (int i = 0; i < 3; i++) begin
                model_exp(i, 1, 0, ev, mk);
                checks++;
                if ((obs[i] & mk) !== (ev & mk)) begin
                    errors++;
                    $display("FAIL reset dut%0d c%0d: got %h want %h", i, c, obs[i] & mk, ev & mk);
                end
                model_step(i, 1, 0, r);
            end
        end
    endtask

    task automatic test_single_frame;
        logic [25:0] ev, mk;
        int fb0 = -1, lb0 = -1, dn0 = -1, fb1 = -1, dn1 = -1, nclr1 = 0, k20 = -1, k21 = -1, rdy47 = -1, lbi0 = -1;
        for (int c = 0; c < 60; c++) begin
            bit bv = (c == 0);
            drive(1, bv, 0);
            for (int i = 0; i < 3; i++) begin
                model_exp(i, 1, bv, ev, mk);
                checks++;
                if ((obs[i] & mk) !== (ev & mk)) begin
                    errors++;
                    if (errors < 40) $display("FAIL single dut%0d c%0d: got %h want %h", i, c, obs[i] & mk, ev & mk);
                end
                model_step(i, 1, bv, 0);
            end
            if (buf_w[0] && fb0 < 0) fb0 = c;
            if (buf_w[0]) begin lb0 = c; lbi0 = int'(bi0); end
            if (done_w[0]) dn0 = c;
            if (buf_w[1] && fb1 < 0) fb1 = c;
            if (done_w[1]) dn1 = c;
            if (clr_w[1]) nclr1++;
            if (c == 20) k20 = int'(k2);
            if (c == 21) k21 = int'(k2);
            if (c == 47) rdy47 = int'(rdy_w[0]);
        end
        checks += 7;
        if (fb0 != 18) begin errors++; $display("FAIL first_buffer_en: got %0d want 18", fb0); end
        if (lb0 != 45 || lbi0 != 3) begin errors++; $display("FAIL last_buffer_en: got %0d idx %0d want 45 idx 3", lb0, lbi0); end
        if (dn0 != 46) begin errors++; $display("FAIL done_cycle: got %0d want 46", dn0); end
        if (rdy47 != 1) begin errors++; $display("FAIL ready_after_done: got %0d want 1", rdy47); end
        if (fb1 != 10 || dn1 != 11) begin errors++; $display("FAIL k1_schedule: got buf %0d done %0d want 10 11", fb1, dn1); end
        if (nclr1 != 1) begin errors++; $display("FAIL k1_clr_count: got %0d want 1", nclr1); end
        if (k20 != 19 || k21 != 0) begin errors++; $display("FAIL kaddr_wrap: got %0d %0d want 19 0", k20, k21); end
    endtask

    task automatic test_busy_hold;
        logic [25:0] ev, mk;
        int nval = 0;
        for (int c = 0; c < 60; c++) begin
            bit bv = (c <= 5);
            drive(1, bv, 0);
            for (int i = 0; i < 3; i++) begin
                model_exp(i, 1, bv, ev, mk);
                checks++;
                if ((obs[i] & mk) !== (ev & mk)) begin
                    errors++;
                    if (errors < 40) $display("FAIL busy dut%0d c%0d: got %h want %h", i, c, obs[i] & mk, ev & mk);
                end
                model_step(i, 1, bv, 0);
            end
            if (val_w[0]) nval++;
        end
        checks++;
        if (nval != 1) begin errors++; $display("FAIL busy_valid_count: got %0d want 1", nval); end
        drive(1, 0, 1);
        for (int i = 0; i < 3; i++) model_step(i, 1, 0, 1);
    endtask

    task automatic test_en_stall;
        logic [25:0] ev, mk;
        int fb0 = -1, dn0 = -1, px5 = -1;
        for (int c = 0; c < 60; c++) begin
            bit bv = (c == 0);
            bit e = !(c >= 4 && c <= 6);
            drive(e, bv, 0);
            for (int i = 0; i < 3; i++) begin
                model_exp(i, e, bv, ev, mk);
                checks++;
                if ((obs[i] & mk) !== (ev & mk)) begin
                    errors++;
                    if (errors < 40) $display("FAIL stall dut%0d c%0d: got %h want %h", i, c, obs[i] & mk, ev & mk);
                end
                model_step(i, e, bv, 0);
            end
            if (c == 5) px5 = int'(pix0);
            if (buf_w[0] && fb0 < 0) fb0 = c;
            if (done_w[0]) dn0 = c;
        end
        checks++;
        if (px5 != 3 || fb0 != 21 || dn0 != 49) begin
            errors++;
            $display("FAIL stall_shift: got pix %0d buf %0d done %0d want 3 21 49", px5, fb0, dn0);
        end
    endtask

    task automatic test_reset_mid;
        logic [25:0] ev, mk;
        int late = 0, rdy21 = -1;
        for (int c = 0; c < 50; c++) begin
            bit bv = (c == 0);
            bit r = (c == 20);
            drive(1, bv, r);
            for (int i = 0; i < 3; i++) begin
                model_exp(i, 1, bv, ev, mk);
                checks++;
                if ((obs[i] & mk) !== (ev & mk)) begin
                    errors++;
                    if (errors < 40) $display("FAIL rstmid dut%0d c%0d: got %h want %h", i, c, obs[i] & mk, ev & mk);
                end
                model_step(i, 1, bv, r);
            end
            if (c == 21) rdy21 = int'(rdy_w[0]);
            if (c > 20 && (bias_w[0] | add_w[0] | act_w[0] | deq_w[0] | qnt_w[0] | buf_w[0] | done_w[0])) late++;
        end
        checks++;
        if (rdy21 != 1 || late != 0) begin
            errors++;
            $display("FAIL rst_mid_frame: got ready %0d late pulses %0d want 1 0", rdy21, late);
        end
    endtask

    task automatic test_back_to_back;
        logic [25:0] ev, mk;
        for (int c = 0; c < 150; c++) begin
            drive(1, 1, 0);
            for (int i = 0; i < 3; i++) begin
                model_exp(i, 1, 1, ev, mk);
                checks++;
                if ((obs[i] & mk) !== (ev & mk)) begin
                    errors++;
                    if (errors < 40) $display("FAIL b2b dut%0d c%0d: got %h want %h", i, c, obs[i] & mk, ev & mk);
                end
                model_step(i, 1, 1, 0);
            end
        end
    endtask

    task automatic test_random;
        logic [25:0] ev, mk;
        for (int c = 0; c < 1500; c++) begin
            bit e  = ($urandom_range(0, 9) != 0);
            bit bv = ($urandom_range(0, 3) == 0);
            bit r  = ($urandom_range(0, 199) == 0);
            drive(e, bv, r);
            for (int i = 0; i < 3; i++) begin
                model_exp(i, e, bv, ev, mk);
                checks++;
                if ((obs[i] & mk) !== (ev & mk)) begin
                    errors++;
                    if (errors < 40) $display("FAIL random dut%0d c%0d: got %h want %h", i, c, obs[i] & mk, ev & mk);
                end
                model_step(i, e, bv, r);
            end
        end
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_busy_hold;
        test_en_stall;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
